// File: rtl/ebox_data_path.sv
// ebox_data_path: 36-bit EBOX data path (AD adder/logic unit, AR/ARX/BR/MQ, FM AC file).
// Bit 0 is the MSB of every 36-bit word.
// Ports:
//   i_master_clk, i_ebox_reset     clock, async active-high reset
//   i_cram_*                       microcode fields AD, ADA, ADB, BR
//   i_cache_data_read, i_ebus_data, i_sh, i_pc   data sources
//   i_ctl_*                        per-cycle control decodes
//   i_fm_blk, i_fm_adr, i_fm_write* FM address and half-word write enables
//   o_ar, o_arx, o_br, o_mq        working registers
//   o_ad_c, o_ad_cry_00_c          combinational adder result and carry out
//   o_ebus_driving_c, o_ebus_data_c EBUS drive request
module ebox_data_path #(
  parameter int unsigned FM_WORDS = 128
) (
  input  logic        i_master_clk,
  input  logic        i_ebox_reset,
  input  logic [5:0]  i_cram_ad,
  input  logic [2:0]  i_cram_ada,
  input  logic [1:0]  i_cram_adb,
  input  logic        i_cram_br,
  input  logic [0:35] i_cache_data_read,
  input  logic [0:35] i_ebus_data,
  input  logic        i_ctl_ad_cry_36,
  input  logic [3:0]  i_ctl_arl_sel,
  input  logic [3:0]  i_ctl_arr_sel,
  input  logic        i_ctl_ar00to08_load,
  input  logic        i_ctl_ar09to17_load,
  input  logic        i_ctl_arr_load,
  input  logic        i_ctl_ar00to11_clr,
  input  logic        i_ctl_ar12to17_clr,
  input  logic        i_ctl_arr_clr,
  input  logic [2:0]  i_ctl_arxl_sel,
  input  logic [2:0]  i_ctl_arxr_sel,
  input  logic        i_ctl_arx_load,
  input  logic [1:0]  i_ctl_mq_sel,
  input  logic        i_ctl_inh_cry_18,
  input  logic        i_ctl_spec_gen_cry_18,
  input  logic        i_ctl_ad_to_ebus_l,
  input  logic        i_ctl_ad_to_ebus_r,
  input  logic [0:35] i_sh,
  input  logic [2:0]  i_fm_blk,
  input  logic [3:0]  i_fm_adr,
  input  logic        i_fm_write00_17,
  input  logic        i_fm_write18_35,
  input  logic [0:35] i_pc,
  output logic [0:35] o_ad_c,
  output logic [0:35] o_ar,
  output logic [0:35] o_arx,
  output logic [0:35] o_br,
  output logic [0:35] o_mq,
  output logic        o_ad_cry_00_c,
  output logic        o_ebus_driving_c,
  output logic [0:35] o_ebus_data_c
);

  localparam int unsigned FM_AW = $clog2(FM_WORDS);

  logic [0:35] r_ar, r_arx, r_br, r_mq;
  logic [0:35] r_fm [FM_WORDS];

  logic [FM_AW-1:0] w_fm_addr;
  logic [0:35] w_fm, w_a, w_b, w_bop, w_sum, w_ad;
  logic        w_cin, w_arith, w_cry18;
  logic [18:0] w_sum_r, w_sum_l;
  logic [0:17] w_arl_src, w_arr_src, w_arxl, w_arxr;
  logic [0:35] w_ld_mask, w_clr_mask, w_ar_next, w_arx_next, w_mq_next;

  assign w_fm_addr = FM_AW'({i_fm_blk, i_fm_adr});
  assign w_fm      = r_fm[w_fm_addr];

  // A and B operand selection
  always_comb begin
    w_a = '0;
    case (i_cram_ada)
      3'd0:    w_a = r_ar;
      3'd1:    w_a = r_arx;
      3'd2:    w_a = r_mq;
      3'd3:    w_a = i_pc;
      default: w_a = '0;
    endcase
    w_b = w_fm;
    case (i_cram_adb)
      2'd0:    w_b = w_fm;
      2'd1:    w_b = {r_br[1:35], 1'b0};
      2'd2:    w_b = r_br;
      default: w_b = {r_ar[2:35], 2'b00};
    endcase
  end

  // Split adder: right half carry into bit 17 is forced or inhibited by CTL
  always_comb begin
    w_bop   = w_b;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    case (i_cram_ad)
      6'o04: begin w_bop = w_b;  w_cin = i_ctl_ad_cry_36; w_arith = 1'b1; end
      6'o05: begin w_bop = ~w_b; w_cin = 1'b1;            w_arith = 1'b1; end
      6'o12: begin w_bop = '0;   w_cin = 1'b1;            w_arith = 1'b1; end
      default: ;
    endcase
    w_sum_r = {1'b0, w_a[18:35]} + {1'b0, w_bop[18:35]} + 19'(w_cin);
    w_cry18 = i_ctl_inh_cry_18 ? 1'b0 : (i_ctl_spec_gen_cry_18 ? 1'b1 : w_sum_r[18]);
    w_sum_l = {1'b0, w_a[0:17]} + {1'b0, w_bop[0:17]} + 19'(w_cry18);
    w_sum   = {w_sum_l[17:0], w_sum_r[17:0]};
  end

  // AD function select
  always_comb begin
    w_ad = '0;
    case (i_cram_ad)
      6'o00:                 w_ad = w_a;
      6'o01:                 w_ad = w_b;
      6'o03:                 w_ad = '1;
      6'o04, 6'o05, 6'o12:   w_ad = w_sum;
      6'o06:                 w_ad = w_a & w_b;
      6'o07:                 w_ad = w_a | w_b;
      6'o10:                 w_ad = w_a ^ w_b;
      6'o11:                 w_ad = ~w_a;
      default:               w_ad = '0;
    endcase
  end

  assign o_ad_c           = w_ad;
  assign o_ad_cry_00_c    = w_arith & w_sum_l[18];
  assign o_ebus_driving_c = i_ctl_ad_to_ebus_l | i_ctl_ad_to_ebus_r;
  assign o_ebus_data_c    = {w_ad[0:17] & {18{i_ctl_ad_to_ebus_l}},
                             w_ad[18:35] & {18{i_ctl_ad_to_ebus_r}}};

  // AR half-word sources; unused selects hold the current value
  always_comb begin
    w_arl_src = r_ar[0:17];
    case (i_ctl_arl_sel)
      4'd1:    w_arl_src = i_cache_data_read[0:17];
      4'd2:    w_arl_src = w_ad[0:17];
      4'd3:    w_arl_src = i_ebus_data[0:17];
      4'd4:    w_arl_src = i_sh[0:17];
      4'd5:    w_arl_src = w_ad[1:18];
      4'd6:    w_arl_src = '0;
      default: w_arl_src = r_ar[0:17];
    endcase
    w_arr_src = r_ar[18:35];
    case (i_ctl_arr_sel)
      4'd1:    w_arr_src = i_cache_data_read[18:35];
      4'd2:    w_arr_src = w_ad[18:35];
      4'd3:    w_arr_src = i_ebus_data[18:35];
      4'd4:    w_arr_src = i_sh[18:35];
      4'd5:    w_arr_src = {w_ad[19:35], 1'b0};
      4'd6:    w_arr_src = '0;
      default: w_arr_src = r_ar[18:35];
    endcase
  end

  // Segment masks: clears override loads bit by bit
  assign w_ld_mask  = {{9{i_ctl_ar00to08_load}}, {9{i_ctl_ar09to17_load}}, {18{i_ctl_arr_load}}};
  assign w_clr_mask = {{12{i_ctl_ar00to11_clr}}, {6{i_ctl_ar12to17_clr}}, {18{i_ctl_arr_clr}}};
  assign w_ar_next  = ((r_ar & ~w_ld_mask) | ({w_arl_src, w_arr_src} & w_ld_mask)) & ~w_clr_mask;

  // ARX and MQ next values
  always_comb begin
    w_arxl = r_arx[0:17];
    case (i_ctl_arxl_sel)
      3'd1:    w_arxl = i_cache_data_read[0:17];
      3'd2:    w_arxl = w_ad[0:17];
      3'd3:    w_arxl = r_mq[0:17];
      default: w_arxl = r_arx[0:17];
    endcase
    w_arxr = r_arx[18:35];
    case (i_ctl_arxr_sel)
      3'd1:    w_arxr = i_cache_data_read[18:35];
      3'd2:    w_arxr = w_ad[18:35];
      3'd3:    w_arxr = r_mq[18:35];
      default: w_arxr = r_arx[18:35];
    endcase
    w_arx_next = i_ctl_arx_load ? {w_arxl, w_arxr} : r_arx;
    w_mq_next  = r_mq;
    case (i_ctl_mq_sel)
      2'd1:    w_mq_next = w_ad;
      2'd2:    w_mq_next = {r_mq[1:35], 1'b0};
      2'd3:    w_mq_next = {1'b0, r_mq[0:34]};
      default: w_mq_next = r_mq;
    endcase
  end

  // Working registers
  always_ff @(posedge i_master_clk or posedge i_ebox_reset) begin
    if (i_ebox_reset) begin
      r_ar  <= '0;
      r_arx <= '0;
      r_br  <= '0;
      r_mq  <= '0;
    end else begin
      r_ar  <= w_ar_next;
      r_arx <= w_arx_next;
      r_mq  <= w_mq_next;
      if (i_cram_br) r_br <= r_ar;
    end
  end

  // FM file: not cleared by reset, writes suppressed while reset is held
  always_ff @(posedge i_master_clk or posedge i_ebox_reset) begin
    if (!i_ebox_reset) begin
      if (i_fm_write00_17) r_fm[w_fm_addr][0:17]  <= r_ar[0:17];
      if (i_fm_write18_35) r_fm[w_fm_addr][18:35] <= r_ar[18:35];
    end
  end

  assign o_ar  = r_ar;
  assign o_arx = r_arx;
  assign o_br  = r_br;
  assign o_mq  = r_mq;

endmodule

// File: tb/tb_ebox_data_path.sv
// tb_ebox_data_path: directed-vector bench for ebox_data_path.
module tb_ebox_data_path;

  localparam logic [5:0] AD_A = 6'o00, AD_B = 6'o01, AD_ZEROS = 6'o02, AD_ONES = 6'o03,
                         AD_APB = 6'o04, AD_AMB = 6'o05, AD_XOR = 6'o10, AD_NOTA = 6'o11,
                         AD_AP1 = 6'o12, AD_BAD = 6'o13;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  cram_ad;
  logic [2:0]  cram_ada;
  logic [1:0]  cram_adb;
  logic        cram_br;
  logic [0:35] cache, ebus, sh, pc;
  logic        cry36, l08, l917, lr, c011, c1217, cr, arx_load, inh, spec, eb_l, eb_r, fw_l, fw_r;
  logic [3:0]  arl_sel, arr_sel, fm_adr;
  logic [2:0]  arxl_sel, arxr_sel, fm_blk;
  logic [1:0]  mq_sel;
  logic [0:35] ad, ar, arx, br, mq, ebus_data;
  logic        cry00, ebus_drv;

  int n_checks = 0;
  int n_errors = 0;

  ebox_data_path #(.FM_WORDS(128)) dut (
    .i_master_clk(clk), .i_ebox_reset(rst),
    .i_cram_ad(cram_ad), .i_cram_ada(cram_ada), .i_cram_adb(cram_adb), .i_cram_br(cram_br),
    .i_cache_data_read(cache), .i_ebus_data(ebus), .i_ctl_ad_cry_36(cry36),
    .i_ctl_arl_sel(arl_sel), .i_ctl_arr_sel(arr_sel),
    .i_ctl_ar00to08_load(l08), .i_ctl_ar09to17_load(l917), .i_ctl_arr_load(lr),
    .i_ctl_ar00to11_clr(c011), .i_ctl_ar12to17_clr(c1217), .i_ctl_arr_clr(cr),
    .i_ctl_arxl_sel(arxl_sel), .i_ctl_arxr_sel(arxr_sel), .i_ctl_arx_load(arx_load),
    .i_ctl_mq_sel(mq_sel), .i_ctl_inh_cry_18(inh), .i_ctl_spec_gen_cry_18(spec),
    .i_ctl_ad_to_ebus_l(eb_l), .i_ctl_ad_to_ebus_r(eb_r), .i_sh(sh),
    .i_fm_blk(fm_blk), .i_fm_adr(fm_adr), .i_fm_write00_17(fw_l), .i_fm_write18_35(fw_r),
    .i_pc(pc), .o_ad_c(ad), .o_ar(ar), .o_arx(arx), .o_br(br), .o_mq(mq),
    .o_ad_cry_00_c(cry00), .o_ebus_driving_c(ebus_drv), .o_ebus_data_c(ebus_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cram_ad = AD_A; cram_ada = 3'd0; cram_adb = 2'd0; cram_br = 1'b0;
    cry36 = 1'b0; arl_sel = 4'd0; arr_sel = 4'd0;
    l08 = 1'b0; l917 = 1'b0; lr = 1'b0; c011 = 1'b0; c1217 = 1'b0; cr = 1'b0;
    arxl_sel = 3'd0; arxr_sel = 3'd0; arx_load = 1'b0; mq_sel = 2'd0;
    inh = 1'b0; spec = 1'b0; eb_l = 1'b0; eb_r = 1'b0; fw_l = 1'b0; fw_r = 1'b0;
  endtask

  task automatic load_ar_cache(input logic [0:35] v);
    cache = v; arl_sel = 4'd1; arr_sel = 4'd1; l08 = 1'b1; l917 = 1'b1; lr = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    cache = '0; ebus = '0; sh = '0; pc = '0; fm_blk = 3'd0; fm_adr = 4'd0;
    idle();
    #75 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ar", ar, 36'h0);
    check_eq("rst_arx", arx, 36'h0);
    check_eq("rst_br", br, 36'h0);
    check_eq("rst_mq", mq, 36'h0);
    check_eq("rst_ad", ad, 36'h0);

    // Load cycles 1 and 2
    load_ar_cache(36'h555555555); cram_br = 1'b1;
    tick();
    check_eq("ld1_ar", ar, 36'h555555555);
    check_eq("ld1_ad", ad, 36'h555555555);
    check_eq("ld1_br", br, 36'h0);
    @(negedge clk); tick();
    check_eq("ld2_br", br, 36'h555555555);

    // Add
    @(negedge clk); idle(); load_ar_cache(36'h987654321);
    cram_ad = AD_APB; cram_adb = 2'd2;
    tick();
    check_eq("add_ad", ad, 36'hEDCBA9876);
    check_eq("add_cry00", 36'(cry00), 36'h0);

    // AD/0S while AR keeps loading
    @(negedge clk); cram_ad = AD_ZEROS;
    tick();
    check_eq("zeros_ad", ad, 36'h0);
    check_eq("zeros_ar", ar, 36'h987654321);

    // Carry 18 setup: AR=1, then BR=1 and AR=3FFFF
    @(negedge clk); idle(); load_ar_cache(36'h000000001);
    tick();
    @(negedge clk); load_ar_cache(36'h00003FFFF); cram_br = 1'b1;
    tick();
    check_eq("c18_br", br, 36'h1);
    @(negedge clk); idle(); cram_ad = AD_APB; cram_adb = 2'd2; #1;
    check_eq("c18_nat", ad, 36'h000040000);
    inh = 1'b1; #1;
    check_eq("c18_inh", ad, 36'h0);
    inh = 1'b0; spec = 1'b1; cram_ada = 3'd4; #1;
    check_eq("c18_spec", ad, 36'h000040001);
    inh = 1'b1; #1;
    check_eq("c18_both", ad, 36'h000000001);
    inh = 1'b0; spec = 1'b0; cram_ada = 3'd0; cry36 = 1'b1; #1;
    check_eq("cin36", ad, 36'h000040001);
    cry36 = 1'b0; cram_ad = AD_AMB; #1;
    check_eq("sub_ad", ad, 36'h00003FFFE);
    check_eq("sub_cry00", 36'(cry00), 36'h1);
    cram_ad = AD_AP1; #1;
    check_eq("ap1_ad", ad, 36'h000040000);
    check_eq("ap1_cry00", 36'(cry00), 36'h0);

    // MQ load and shifts
    cram_ad = AD_A; mq_sel = 2'd1;
    tick();
    check_eq("mq_ld", mq, 36'h00003FFFF);
    @(negedge clk); mq_sel = 2'd2; tick();
    check_eq("mq_shl", mq, 36'h00007FFFE);
    @(negedge clk); mq_sel = 2'd3; tick();
    check_eq("mq_shr", mq, 36'h00003FFFF);

    // ARX half selects, then hold
    @(negedge clk); idle(); cache = 36'hABCDEF012; arx_load = 1'b1; arxl_sel = 3'd1; arxr_sel = 3'd3;
    tick();
    check_eq("arx_ld", arx, 36'hABCDFFFFF);
    @(negedge clk); arx_load = 1'b0; cache = 36'h0; tick();
    check_eq("arx_hold", arx, 36'hABCDFFFFF);

    // AR from EBUS/SH, AD*2, ADX with right hold
    @(negedge clk); idle(); ebus = 36'h123456789; sh = 36'hABCDEF012;
    arl_sel = 4'd3; arr_sel = 4'd4; l08 = 1'b1; l917 = 1'b1; lr = 1'b1;
    tick();
    check_eq("ar_ebus_sh", ar, 36'h12346F012);
    @(negedge clk); arl_sel = 4'd5; arr_sel = 4'd5; tick();
    check_eq("ar_ad2", ar, 36'h2468DE024);
    @(negedge clk); arl_sel = 4'd6; arr_sel = 4'd0; tick();
    check_eq("ar_adx", ar, 36'h00001E024);

    // Segment clears, with an FM write of the old AR value
    @(negedge clk); idle(); load_ar_cache(36'hFFFFFFFFF); tick();
    @(negedge clk); cr = 1'b1; fm_blk = 3'd0; fm_adr = 4'd5; fw_l = 1'b1; fw_r = 1'b1;
    tick();
    check_eq("clr_arr", ar, 36'hFFFFC0000);
    @(negedge clk); cr = 1'b0; fw_l = 1'b0; fw_r = 1'b0; c011 = 1'b1; tick();
    check_eq("clr_ar0011", ar, 36'h000FFFFFF);
    @(negedge clk); c011 = 1'b0; load_ar_cache(36'h987654321); tick();
    @(negedge clk); idle(); fw_l = 1'b1; tick();
    @(negedge clk); idle(); cram_ad = AD_B; cram_adb = 2'd0; #1;
    check_eq("fm_half", ad, 36'h98767FFFF);

    // EBUS drive
    cram_ad = AD_A; eb_l = 1'b1; #1;
    check_eq("ebl_drv", 36'(ebus_drv), 36'h1);
    check_eq("ebl_data", ebus_data, 36'h987640000);
    eb_l = 1'b0; eb_r = 1'b1; #1;
    check_eq("ebr_data", ebus_data, 36'h000014321);
    eb_r = 1'b0; #1;
    check_eq("eb_none", 36'(ebus_drv), 36'h0);

    // Remaining AD functions and operands (AR=987654321, BR=1)
    cram_ad = AD_XOR; cram_adb = 2'd2; #1;
    check_eq("xor", ad, 36'h987654320);
    cram_ad = AD_NOTA; #1;
    check_eq("nota", ad, 36'h6789ABCDE);
    cram_ad = AD_ONES; #1;
    check_eq("ones", ad, 36'hFFFFFFFFF);
    cram_ad = AD_BAD; #1;
    check_eq("undef_fn", ad, 36'h0);
    cram_ad = AD_B; cram_adb = 2'd3; #1;
    check_eq("adb_ar4", ad, 36'h61D950C84);
    cram_ad = AD_A; cram_ada = 3'd3; pc = 36'h0000001F4; #1;
    check_eq("ada_pc", ad, 36'h0000001F4);

    // Async reset: immediate clear, loads ignored, FM kept, clean restart
    @(negedge clk); idle(); rst = 1'b1; #1;
    check_eq("arst_ar", ar, 36'h0);
    check_eq("arst_arx", arx, 36'h0);
    load_ar_cache(36'h111111111); mq_sel = 2'd1;
    tick();
    check_eq("arst_hold", ar, 36'h0);
    @(negedge clk); rst = 1'b0;
    cram_ad = AD_B; cram_adb = 2'd0; fm_adr = 4'd5; mq_sel = 2'd0; #1;
    check_eq("arst_fm", ad, 36'h98767FFFF);
    tick();
    check_eq("arst_reload", ar, 36'h111111111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
